// File: rtl/hazard_forwarding_unit.sv
// Load-use hazard detection and ID-stage operand forwarding for the five-stage pipeline.
// Keeps a shadow copy of dest/load/write info for EX, MEM and WB to drive the operand mux selects.
module hazard_forwarding_unit #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [3:0]             ID_Rn,
  input  logic [3:0]             ID_Rm,
  input  logic [3:0]             ID_Rd_src,
  input  logic                   ID_use_Rn,
  input  logic                   ID_use_Rm,
  input  logic                   ID_use_Rd,
  input  logic [3:0]             ID_dest,
  input  logic                   ID_RF_enable,
  input  logic                   ID_load_instr,
  output logic [1:0]             fwd_Rn,
  output logic [1:0]             fwd_Rm,
  output logic [1:0]             fwd_Rd,
  output logic                   stall,
  output logic                   nop_insert,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       load;
    logic       wr;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  logic  load_use;

  // R15 is excluded here so the PC always comes from the fetch path.
  function automatic logic slot_match(slot_t s, logic [3:0] src);
    return s.valid && s.wr && (s.dest == src) && (src != 4'd15);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [3:0] src, logic use_src,
                                         slot_t ex, slot_t mem, slot_t wb);
    logic [1:0] sel;
    sel = SEL_RF;
    if (use_src) begin
      if (slot_match(ex, src))       sel = SEL_EX;
      else if (slot_match(mem, src)) sel = SEL_MEM;
      else if (slot_match(wb, src))  sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    load_use = ex_slot.load &&
               ((ID_use_Rn && slot_match(ex_slot, ID_Rn)) ||
                (ID_use_Rm && slot_match(ex_slot, ID_Rm)) ||
                (ID_use_Rd && slot_match(ex_slot, ID_Rd_src)));
  end

  always_comb begin
    fwd_Rn     = SEL_RF;
    fwd_Rm     = SEL_RF;
    fwd_Rd     = SEL_RF;
    stall      = load_use;
    nop_insert = load_use;
    if (!load_use) begin
      fwd_Rn = fwd_sel(ID_Rn,     ID_use_Rn, ex_slot, mem_slot, wb_slot);
      fwd_Rm = fwd_sel(ID_Rm,     ID_use_Rm, ex_slot, mem_slot, wb_slot);
      fwd_Rd = fwd_sel(ID_Rd_src, ID_use_Rd, ex_slot, mem_slot, wb_slot);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ex_slot     <= '0;
      mem_slot    <= '0;
      wb_slot     <= '0;
      stall_count <= '0;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      if (stall) begin
        ex_slot <= '0;
      end else begin
        ex_slot.valid <= 1'b1;
        ex_slot.dest  <= ID_dest;
        ex_slot.load  <= ID_load_instr;
        ex_slot.wr    <= ID_RF_enable;
      end
      if (stall && (stall_count != '1))
        stall_count <= stall_count + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: timeline model of issued instructions plus directed literal checks.
// A second instance with a 2-bit counter exercises stall_count saturation.
module tb_hazard_forwarding_unit;

  logic       clk;
  logic       clr;
  logic [3:0] ID_Rn, ID_Rm, ID_Rd_src, ID_dest;
  logic       ID_use_Rn, ID_use_Rm, ID_use_Rd, ID_RF_enable, ID_load_instr;
  logic [1:0] fwd_Rn, fwd_Rm, fwd_Rd;
  logic       stall, nop_insert;
  logic [15:0] stall_count;
  logic [1:0] s_fwd_Rn, s_fwd_Rm, s_fwd_Rd;
  logic       s_stall, s_nop_insert;
  logic [1:0] s_stall_count;

  int total = 0;
  int bad   = 0;

  hazard_forwarding_unit #(.STALL_CNT_W(16)) dut (
    .clk(clk), .clr(clr),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd_src(ID_Rd_src),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .ID_dest(ID_dest), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
    .fwd_Rn(fwd_Rn), .fwd_Rm(fwd_Rm), .fwd_Rd(fwd_Rd),
    .stall(stall), .nop_insert(nop_insert), .stall_count(stall_count)
  );

  hazard_forwarding_unit #(.STALL_CNT_W(2)) dut_small (
    .clk(clk), .clr(clr),
    .ID_Rn(ID_Rn), .ID_Rm(ID_Rm), .ID_Rd_src(ID_Rd_src),
    .ID_use_Rn(ID_use_Rn), .ID_use_Rm(ID_use_Rm), .ID_use_Rd(ID_use_Rd),
    .ID_dest(ID_dest), .ID_RF_enable(ID_RF_enable), .ID_load_instr(ID_load_instr),
    .fwd_Rn(s_fwd_Rn), .fwd_Rm(s_fwd_Rm), .fwd_Rd(s_fwd_Rd),
    .stall(s_stall), .nop_insert(s_nop_insert), .stall_count(s_stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline model: what entered EX on each cycle; distance d back = EX(1), MEM(2), WB(3).
  localparam int DEPTH = 256;
  logic       h_valid [DEPTH];
  logic [3:0] h_dest  [DEPTH];
  logic       h_wr    [DEPTH];
  logic       h_ld    [DEPTH];
  int cyc        = 0;
  int last_reset = -1;
  bit have_reset = 0;
  int cnt        = 0;

  function automatic bit writes(int k, logic [3:0] s);
    if (k < 0 || k <= last_reset || k >= DEPTH) return 0;
    return h_valid[k] && h_wr[k] && (h_dest[k] == s) && (s != 4'd15);
  endfunction

  function automatic int exp_sel(logic [3:0] s, logic u);
    if (!u || s == 4'd15) return 0;
    for (int d = 1; d <= 3; d++)
      if (writes(cyc - d, s)) return d;
    return 0;
  endfunction

  function automatic bit exp_hazard();
    int k;
    k = cyc - 1;
    if (k < 0 || k <= last_reset || k >= DEPTH || !h_ld[k]) return 0;
    return (ID_use_Rn && writes(k, ID_Rn)) ||
           (ID_use_Rm && writes(k, ID_Rm)) ||
           (ID_use_Rd && writes(k, ID_Rd_src));
  endfunction

  always @(negedge clk) begin
    bit hz;
    hz = exp_hazard();
    if (have_reset && cyc < DEPTH) begin
      chk("mdl_stall",      int'(stall),      int'(hz));
      chk("mdl_nop_insert", int'(nop_insert), int'(hz));
      chk("mdl_fwd_Rn", int'(fwd_Rn), hz ? 0 : exp_sel(ID_Rn, ID_use_Rn));
      chk("mdl_fwd_Rm", int'(fwd_Rm), hz ? 0 : exp_sel(ID_Rm, ID_use_Rm));
      chk("mdl_fwd_Rd", int'(fwd_Rd), hz ? 0 : exp_sel(ID_Rd_src, ID_use_Rd));
      chk("mdl_stall_count",   int'(stall_count),   (cnt > 65535) ? 65535 : cnt);
      chk("mdl_stall_count_w2", int'(s_stall_count), (cnt > 3) ? 3 : cnt);
      chk("mdl_small_stall", int'(s_stall), int'(hz));
    end
    if (cyc < DEPTH) begin
      h_valid[cyc] = !hz;
      h_dest[cyc]  = ID_dest;
      h_wr[cyc]    = ID_RF_enable;
      h_ld[cyc]    = ID_load_instr;
    end
    if (clr) begin
      last_reset = cyc;
      have_reset = 1;
      cnt        = 0;
    end else if (hz) begin
      cnt++;
    end
    cyc++;
  end

  task automatic apply(input logic c, input logic [3:0] rn, input logic urn,
                       input logic [3:0] rm, input logic urm,
                       input logic [3:0] rd, input logic urd,
                       input logic [3:0] dest, input logic wr, input logic ld);
    @(posedge clk);
    #1;
    clr = c;
    ID_Rn = rn;     ID_use_Rn = urn;
    ID_Rm = rm;     ID_use_Rm = urm;
    ID_Rd_src = rd; ID_use_Rd = urd;
    ID_dest = dest; ID_RF_enable = wr; ID_load_instr = ld;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    clr = 1'b1;
    ID_Rn = '0; ID_Rm = '0; ID_Rd_src = '0; ID_dest = '0;
    ID_use_Rn = 1'b0; ID_use_Rm = 1'b0; ID_use_Rd = 1'b0;
    ID_RF_enable = 1'b0; ID_load_instr = 1'b0;

    // reset with arbitrary ID inputs
    apply(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1);
    apply(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
    idle();
    chk("lit_reset_fwd_Rn", int'(fwd_Rn), 0);
    chk("lit_reset_fwd_Rm", int'(fwd_Rm), 0);
    chk("lit_reset_fwd_Rd", int'(fwd_Rd), 0);
    chk("lit_reset_stall", int'(stall), 0);
    chk("lit_reset_nop", int'(nop_insert), 0);
    chk("lit_reset_count", int'(stall_count), 0);

    // back-to-back ALU forwarding through EX, MEM, WB, then RF
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    apply(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_alu_ex", int'(fwd_Rn), 1);
    chk("lit_alu_ex_stall", int'(stall), 0);
    apply(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_alu_mem", int'(fwd_Rn), 2);
    apply(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_alu_wb", int'(fwd_Rn), 3);
    apply(1'b0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_alu_rf", int'(fwd_Rn), 0);

    // load-use: one bubble then MEM forward
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
    apply(1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_lu_stall", int'(stall), 1);
    chk("lit_lu_nop", int'(nop_insert), 1);
    chk("lit_lu_fwd", int'(fwd_Rm), 0);
    apply(1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_lu_after_stall", int'(stall), 0);
    chk("lit_lu_after_fwd", int'(fwd_Rm), 2);
    chk("lit_lu_after_count", int'(stall_count), 1);

    // EX beats MEM on same register; R15 never forwarded
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    apply(1'b0, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
    chk("lit_prio_ex", int'(fwd_Rn), 1);
    apply(1'b0, 4'd15, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_r15", int'(fwd_Rn), 0);

    // no-write producer, unused source, independent selects
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b0, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("lit_nowrite", int'(fwd_Rd), 0);
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b0, 4'd6, 1'b1, 1'b0);
    chk("lit_unused", int'(fwd_Rd), 0);
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    apply(1'b0, 4'd7, 1'b1, 4'd6, 1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("lit_indep_Rn", int'(fwd_Rn), 1);
    chk("lit_indep_Rm", int'(fwd_Rm), 2);
    chk("lit_indep_Rd", int'(fwd_Rd), 3);

    // reset while stalled
    apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1, 1'b1);
    apply(1'b1, 4'd8, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("lit_clr_in_stall", int'(stall), 1);
    idle();
    chk("lit_clr_stall", int'(stall), 0);
    chk("lit_clr_count", int'(stall_count), 0);

    // five load-use stalls: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
      apply(1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd9, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    end
    chk("lit_sat_w2", int'(s_stall_count), 3);
    chk("lit_sat_w16", int'(stall_count), 5);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
